// File: rtl/edgcol_collision_unit_if.sv
// Bus bundle for the edge-collision checker: pass control,
// edge words, occupancy write port and pass status.
interface edgcol_collision_unit_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 start;
    logic [5:0]           edge_mask;
    logic [BUS_WIDTH-1:0] e0;
    logic [BUS_WIDTH-1:0] e1;
    logic [BUS_WIDTH-1:0] e2;
    logic [BUS_WIDTH-1:0] e3;
    logic [BUS_WIDTH-1:0] e4;
    logic [BUS_WIDTH-1:0] e5;
    logic                 occ_wr_ena;
    logic [4:0]           occ_wr_row;
    logic [BUS_WIDTH-1:0] occ_wr_data;
    logic                 busy;
    logic                 done;
    logic [5:0]           collision;

    modport master (
        output start, edge_mask,
        output e0, e1, e2, e3, e4, e5,
        output occ_wr_ena, occ_wr_row, occ_wr_data,
        input  busy, done, collision
    );

    modport slave (
        input  start, edge_mask,
        input  e0, e1, e2, e3, e4, e5,
        input  occ_wr_ena, occ_wr_row, occ_wr_data,
        output busy, done, collision
    );
endinterface

// File: rtl/edgcol_collision_unit.sv
// Edge collision checker: rasterises up to six snapshotted edges
// with Bresenham over a 32x32 occupancy grid, one cell per cycle.
module edgcol_collision_unit #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstb,
    edgcol_collision_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [5:0]           mask_q, mask_d;
    logic [19:0]          snap_q [6];
    logic [19:0]          snap_d [6];
    logic [BUS_WIDTH-1:0] grid_q [32];
    logic [BUS_WIDTH-1:0] grid_d [32];
    logic [4:0]           x_q, x_d;
    logic [4:0]           y_q, y_d;
    logic signed [7:0]    dx_q, dx_d;
    logic signed [7:0]    dy_q, dy_d;
    logic signed [7:0]    err_q, err_d;
    logic                 sxn_q, sxn_d;
    logic                 syn_q, syn_d;
    logic [5:0]           coll_q, coll_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Only the coordinate fields of each edge word are meaningful.
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.e0[11:0], bus.e1[11:0], bus.e2[11:0],
                           bus.e3[11:0], bus.e4[11:0], bus.e5[11:0]};

    logic [19:0]       cur;
    logic [4:0]        cx0, cy0, cx1, cy1;
    logic [4:0]        adx, ady;
    logic signed [7:0] e2;
    logic signed [7:0] acc;
    logic              hit;
    logic              at_end;
    logic              last;

    assign cur  = snap_q[idx_q];
    assign cx0  = cur[19:15];
    assign cy0  = cur[14:10];
    assign cx1  = cur[9:5];
    assign cy1  = cur[4:0];
    assign adx  = (cx1 > cx0) ? (cx1 - cx0) : (cx0 - cx1);
    assign ady  = (cy1 > cy0) ? (cy1 - cy0) : (cy0 - cy1);
    assign hit  = grid_q[y_q][x_q];
    assign at_end = (x_q == cx1) && (y_q == cy1);
    assign last = (idx_q == 3'd5);

    // Next-state: grid write port, pass FSM and Bresenham stepping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        snap_d  = snap_q;
        grid_d  = grid_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        coll_d  = coll_q;
        e2      = err_q <<< 1;
        acc     = err_q;

        if (bus.occ_wr_ena) begin
            grid_d[bus.occ_wr_row] = bus.occ_wr_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    snap_d[0] = bus.e0[31:12];
                    snap_d[1] = bus.e1[31:12];
                    snap_d[2] = bus.e2[31:12];
                    snap_d[3] = bus.e3[31:12];
                    snap_d[4] = bus.e4[31:12];
                    snap_d[5] = bus.e5[31:12];
                    mask_d    = bus.edge_mask;
                    coll_d    = 6'd0;
                    idx_d     = 3'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!mask_q[idx_q]) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    x_d     = cx0;
                    y_d     = cy0;
                    dx_d    = {3'b000, adx};
                    dy_d    = 8'sd0 - {3'b000, ady};
                    err_d   = {3'b000, adx} - {3'b000, ady};
                    sxn_d   = !(cx0 < cx1);
                    syn_d   = !(cy0 < cy1);
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (hit) begin
                    coll_d[idx_q] = 1'b1;
                end
                if (hit || at_end) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    if (e2 >= dy_q) begin
                        acc = acc + dy_q;
                        x_d = sxn_q ? (x_q - 5'd1) : (x_q + 5'd1);
                    end
                    if (e2 <= dx_q) begin
                        acc = acc + dx_q;
                        y_d = syn_q ? (y_q - 5'd1) : (y_q + 5'd1);
                    end
                    err_d = acc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_STEP);
        done_d = (state_d == S_DONE);
    end

    // State registers; reset aborts any pass and clears the grid.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            mask_q  <= 6'd0;
            for (int i = 0; i < 6; i++) begin
                snap_q[i] <= '0;
            end
            for (int r = 0; r < 32; r++) begin
                grid_q[r] <= '0;
            end
            x_q     <= 5'd0;
            y_q     <= 5'd0;
            dx_q    <= 8'sd0;
            dy_q    <= 8'sd0;
            err_q   <= 8'sd0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            coll_q  <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            snap_q  <= snap_d;
            grid_q  <= grid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sxn_q   <= sxn_d;
            syn_q   <= syn_d;
            coll_q  <= coll_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.collision = coll_q;

endmodule

// File: tb/tb_edgcol_collision_unit.sv
// Directed bench for edgcol_collision_unit: pass latency,
// collision vectors, ignored start, live writes and resets.
module tb_edgcol_collision_unit;

    logic clk;
    logic rstb;

    edgcol_collision_unit_if #(.BUS_WIDTH(32)) bus ();

    edgcol_collision_unit #(.BUS_WIDTH(32)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int n_cmp;
    int n_bad;
    int nb;
    int da;
    int nd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int x0, input int y0,
                                       input int x1, input int y1);
        logic [4:0] a, b, c, d;
        a = x0[4:0];
        b = y0[4:0];
        c = x1[4:0];
        d = y1[4:0];
        return {a, b, c, d, 12'h5a5};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int r, input logic [31:0] d);
        bus.occ_wr_ena  = 1'b1;
        bus.occ_wr_row  = r[4:0];
        bus.occ_wr_data = d;
        tick;
        bus.occ_wr_ena  = 1'b0;
    endtask

    task automatic do_reset;
        rstb = 1'b0;
        tick;
        tick;
        rstb = 1'b1;
        tick;
    endtask

    // poke > 0: at that cycle re-pulse start with a different
    // snapshot and write row 15 = 1 while the pass is running.
    task automatic run_pass(input logic [5:0] m, input int poke);
        bus.edge_mask = m;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        nb = 0;
        da = 0;
        nd = 0;
        for (int c = 1; c < 400; c++) begin
            if (poke > 0 && c == poke) begin
                bus.start       = 1'b1;
                bus.edge_mask   = 6'h3f;
                bus.e0          = mk(31, 31, 31, 31);
                bus.occ_wr_ena  = 1'b1;
                bus.occ_wr_row  = 5'd15;
                bus.occ_wr_data = 32'h1;
            end else if (poke > 0 && c == poke + 1) begin
                bus.start      = 1'b0;
                bus.occ_wr_ena = 1'b0;
            end
            if (bus.busy) nb++;
            if (bus.done) begin
                nd++;
                if (da == 0) da = c;
            end
            if (da != 0 && c >= da + 3) break;
            tick;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstb  = 1'b0;
        bus.start       = 1'b0;
        bus.edge_mask   = 6'd0;
        bus.e0          = '0;
        bus.e1          = '0;
        bus.e2          = '0;
        bus.e3          = '0;
        bus.e4          = '0;
        bus.e5          = '0;
        bus.occ_wr_ena  = 1'b0;
        bus.occ_wr_row  = 5'd0;
        bus.occ_wr_data = '0;
        tick;
        tick;
        rstb = 1'b1;
        tick;

        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_coll", {26'd0, bus.collision}, 0);

        // horizontal hit at (3,0)
        write_row(0, 32'h8);
        bus.e0 = mk(0, 0, 5, 0);
        run_pass(6'b000001, 0);
        chk("horiz_busy", nb, 10);
        chk("horiz_done_at", da, 11);
        chk("horiz_ndone", nd, 1);
        chk("horiz_coll", {26'd0, bus.collision}, 1);

        // async reset mid-cycle clears outputs at once
        @(posedge clk);
        #3;
        rstb = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 0);
        chk("arst_done", {31'd0, bus.done}, 0);
        chk("arst_coll", {26'd0, bus.collision}, 0);
        tick;
        rstb = 1'b1;
        tick;
        run_pass(6'b000001, 0);
        chk("arst_grid_coll", {26'd0, bus.collision}, 0);
        chk("arst_grid_busy", nb, 12);

        // empty grid, six full diagonals
        bus.e0 = mk(0, 0, 31, 31);
        bus.e1 = mk(0, 0, 31, 31);
        bus.e2 = mk(0, 0, 31, 31);
        bus.e3 = mk(0, 0, 31, 31);
        bus.e4 = mk(0, 0, 31, 31);
        bus.e5 = mk(0, 0, 31, 31);
        run_pass(6'h3f, 0);
        chk("diag_busy", nb, 198);
        chk("diag_done_at", da, 199);
        chk("diag_coll", {26'd0, bus.collision}, 0);

        // mask 0: six LOAD cycles only
        run_pass(6'h00, 0);
        chk("nomask_busy", nb, 6);
        chk("nomask_done_at", da, 7);

        // steep negative slope plus degenerate edge on (2,7)
        write_row(7, 32'h4);
        bus.e1 = mk(3, 9, 1, 3);
        bus.e2 = mk(2, 7, 2, 7);
        run_pass(6'b000110, 0);
        chk("steep_busy", nb, 10);
        chk("steep_done_at", da, 11);
        chk("steep_coll", {26'd0, bus.collision}, 6);

        // ignored start and live write ahead of the edge
        do_reset;
        bus.e0 = mk(0, 0, 0, 20);
        run_pass(6'b000001, 3);
        chk("live_busy", nb, 22);
        chk("live_done_at", da, 23);
        chk("live_ndone", nd, 1);
        chk("live_coll", {26'd0, bus.collision}, 1);

        // reset during STEP: no done, grid cleared
        do_reset;
        write_row(20, 32'h0010_0000);
        write_row(30, 32'h1);
        bus.e0 = mk(0, 0, 31, 31);
        bus.e1 = mk(0, 30, 31, 30);
        bus.edge_mask = 6'b000011;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 0; c < 5; c++) tick;
        chk("mid_busy_pre", {31'd0, bus.busy}, 1);
        #2;
        rstb = 1'b0;
        nd = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.done) nd++;
            tick;
        end
        rstb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (bus.done) nd++;
            tick;
        end
        chk("mid_ndone", nd, 0);
        chk("mid_busy_post", {31'd0, bus.busy}, 0);
        run_pass(6'b000011, 0);
        chk("mid_grid_coll", {26'd0, bus.collision}, 0);
        chk("mid_grid_busy", nb, 70);
        chk("mid_grid_done_at", da, 71);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
